draw_port_arbiter: RTL and testbench
====================================

DRAW_PORT_ARBITER -- requirements
Module: draw_port_arbiter

Interface
REQ-001 The block SHALL expose these ports, in order:
  clk          in   1   system clock; all state changes on rising edge
  reset        in   1   synchronous, active-high reset
  enable       in   1   when 0, no new grant issued; an active burst completes
  req_valid    in   4   per-requester pixel valid (0 background, 1 sprite, 2 hook, 3 num/overlay)
  req_last     in   4   per-requester final pixel of burst, qualified by req_valid
  req_x        in   32  4 x 8-bit x coordinate, requester i at bits [8i+7:8i]
  req_y        in   28  4 x 7-bit y coordinate, requester i at bits [7i+6:7i]
  req_colour   in   12  4 x 3-bit colour, requester i at bits [3i+2:3i]
  req_ready    out  4   per-requester accept; only granted bit may be 1
  vga_x        out  8   framebuffer write x
  vga_y        out  7   framebuffer write y
  vga_colour   out  3   framebuffer write colour
  vga_plot     out  1   framebuffer write enable, one pixel per cycle
  grant_id     out  2   index of current/last granted requester
  busy         out  1   1 while a burst is locked
  drop_count   out  8   saturating count of dropped out-of-range pixels
REQ-002 Clock and reset SHALL be one clock domain; reset is synchronous and active-high.

Function
REQ-003 Two states SHALL exist: IDLE, LOCKED.
REQ-004 In IDLE with enable=1 and any req_valid=1, the arbiter SHALL select the first requester with req_valid=1 searching round-robin from (last_grant+1) mod 4, set grant_id, and enter LOCKED next cycle; req_ready SHALL be 0 in IDLE.
REQ-005 In IDLE with enable=0, the state SHALL remain IDLE regardless of req_valid.
REQ-006 In LOCKED, req_ready[grant_id] SHALL equal req_valid[grant_id] (combinational); all other req_ready bits 0.
REQ-007 A transfer SHALL occur when req_valid[g] and req_ready[g] are both 1; exactly one transfer per cycle maximum.
REQ-008 For each transfer, vga_x/vga_y/vga_colour SHALL be registered from requester g and vga_plot SHALL be 1 on the following cycle (latency 1); otherwise vga_plot SHALL be 0 and vga_x/y/colour hold.
REQ-009 A transfer with x>159 or y>119 SHALL be accepted but not plotted (vga_plot=0) and SHALL increment drop_count, saturating at 255.
REQ-010 A transfer with req_last[g]=1 SHALL return the state to IDLE next cycle; last_grant SHALL update to g.
REQ-011 Watchdog: if in LOCKED req_valid[g]=0 for 16 consecutive cycles, the state SHALL return to IDLE, last_grant=g; counter clears on any transfer.
REQ-012 enable falling during LOCKED SHALL NOT abort the burst.
REQ-013 Requests from non-granted requesters SHALL be ignored (not queued) until the next IDLE arbitration; requesters hold req_valid until ready.
REQ-014 busy SHALL equal 1 exactly in LOCKED.
REQ-015 Re-arbitration SHALL take one IDLE cycle between bursts (no back-to-back grant without IDLE).

Reset
REQ-016 On reset=1 at a clock edge: state=IDLE, last_grant=3 (so requester 0 wins first), grant_id=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, drop_count=0, watchdog=0; reset during LOCKED SHALL abort the burst with no further plot.

Structure
REQ-017 Shared package SHALL hold: requester count (4), coordinate widths (8/7), colour width (3), screen limits (160/120), watchdog length (16), requester index constants.
REQ-018 Round-robin selection SHALL be one sub-module, rr_select (4-bit request, 2-bit last grant in; valid + 2-bit index out, combinational); the rest is one flat module.

Verification
REQ-019 Reset, then req_valid=0001 with 3-pixel burst (last on 3rd) -> grant_id=0, vga_plot high on 3 consecutive cycles starting 2 cycles after request, busy drops after last.
REQ-020 req_valid=1111 held, each burst 1 pixel, last_grant=3 -> grant order 0,1,2,3,0 with one IDLE cycle between.
REQ-021 Granted requester sends x=160,y=5 then x=159,y=119 -> first not plotted, drop_count=1; second plotted at (159,119).
REQ-022 Granted requester drops req_valid mid-burst for 16 cycles -> busy falls after 16th idle cycle, next requester granted.
REQ-023 enable=0 with req_valid=0100 -> no grant, vga_plot=0; enable lowered mid-burst -> burst completes to req_last.
REQ-024 Assert reset mid-burst -> next cycle vga_plot=0, busy=0, drop_count=0, grant goes to requester 0 first after release.

Source files
------------

// File: rtl/draw_port_arbiter_pkg.sv
// Shared constants and types for the draw-port arbiter: requester map, pixel
// field widths, screen limits and the watchdog length.
package draw_port_arbiter_pkg;

    localparam int unsigned NumReq      = 4;
    localparam int unsigned IdxW        = 2;
    localparam int unsigned CoordXW     = 8;
    localparam int unsigned CoordYW     = 7;
    localparam int unsigned ColourW     = 3;
    localparam int unsigned ScreenW     = 160;
    localparam int unsigned ScreenH     = 120;
    localparam int unsigned WatchdogLen = 16;
    localparam int unsigned WdW         = 4;

    localparam logic [IdxW-1:0] ReqBackground = 2'd0;
    localparam logic [IdxW-1:0] ReqSprite     = 2'd1;
    localparam logic [IdxW-1:0] ReqHook       = 2'd2;
    localparam logic [IdxW-1:0] ReqOverlay    = 2'd3;

    typedef enum logic {
        StIdle,
        StLocked
    } state_e;

    function automatic logic on_screen(input logic [CoordXW-1:0] x,
                                       input logic [CoordYW-1:0] y);
        return (32'(x) < ScreenW) && (32'(y) < ScreenH);
    endfunction

endpackage

// File: rtl/draw_port_arbiter_rr_select.sv
// Combinational round-robin pick: first set request bit starting after the
// previous grant.
module rr_select
    import draw_port_arbiter_pkg::*;
(
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   last,
    output logic              valid,
    output logic [IdxW-1:0]   idx
);

    logic [IdxW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = last;
        cand  = last;
        // i == NumReq wraps back to last, so the previous winner is tried last
        for (int i = 1; i <= NumReq; i++) begin
            cand = last + IdxW'(i);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/draw_port_arbiter.sv
// Four-way burst arbiter for the VGA framebuffer write port with off-screen
// pixel dropping and a stalled-burst watchdog.
module draw_port_arbiter
    import draw_port_arbiter_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NumReq-1:0]           req_valid,
    input  logic [NumReq-1:0]           req_last,
    input  logic [NumReq*CoordXW-1:0]   req_x,
    input  logic [NumReq*CoordYW-1:0]   req_y,
    input  logic [NumReq*ColourW-1:0]   req_colour,
    output logic [NumReq-1:0]           req_ready,
    output logic [CoordXW-1:0]          vga_x,
    output logic [CoordYW-1:0]          vga_y,
    output logic [ColourW-1:0]          vga_colour,
    output logic                        vga_plot,
    output logic [IdxW-1:0]             grant_id,
    output logic                        busy,
    output logic [7:0]                  drop_count
);

    state_e          state_q, state_d;
    logic [IdxW-1:0] last_grant_q, last_grant_d;
    logic [IdxW-1:0] grant_d;
    logic [WdW-1:0]  wd_q, wd_d;

    logic            sel_valid;
    logic [IdxW-1:0] sel_idx;
    logic            xfer;
    logic [CoordXW-1:0] g_x;
    logic [CoordYW-1:0] g_y;
    logic [ColourW-1:0] g_colour;
    logic            g_last;

    rr_select u_rr_select (
        .req   (req_valid),
        .last  (last_grant_q),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    assign g_x      = req_x[int'(grant_id)*CoordXW +: CoordXW];
    assign g_y      = req_y[int'(grant_id)*CoordYW +: CoordYW];
    assign g_colour = req_colour[int'(grant_id)*ColourW +: ColourW];
    assign g_last   = req_last[grant_id];
    assign busy     = (state_q == StLocked);
    assign xfer     = busy && req_valid[grant_id];

    always_comb begin
        req_ready = '0;
        if (busy) begin
            req_ready[grant_id] = req_valid[grant_id];
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_id;
        last_grant_d = last_grant_q;
        wd_d         = wd_q;
        unique case (state_q)
            StIdle: begin
                wd_d = '0;
                if (enable && sel_valid) begin
                    grant_d = sel_idx;
                    state_d = StLocked;
                end
            end
            StLocked: begin
                if (xfer) begin
                    wd_d = '0;
                    if (g_last) begin
                        state_d      = StIdle;
                        last_grant_d = grant_id;
                    end
                end else if (wd_q == WdW'(WatchdogLen - 1)) begin
                    // Requester stalled too long: release the port
                    state_d      = StIdle;
                    last_grant_d = grant_id;
                    wd_d         = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= ReqOverlay;
            grant_id     <= ReqBackground;
            wd_q         <= '0;
            vga_plot     <= 1'b0;
            vga_x        <= '0;
            vga_y        <= '0;
            vga_colour   <= '0;
            drop_count   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id     <= grant_d;
            wd_q         <= wd_d;
            vga_plot     <= 1'b0;
            if (xfer) begin
                if (on_screen(g_x, g_y)) begin
                    vga_plot   <= 1'b1;
                    vga_x      <= g_x;
                    vga_y      <= g_y;
                    vga_colour <= g_colour;
                end else if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_draw_port_arbiter.sv
// Scoreboard bench for draw_port_arbiter: accepted pixels are predicted from
// the bench's own stimulus and matched against the framebuffer write port.
module tb_draw_port_arbiter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_x;
    logic [27:0] req_y;
    logic [11:0] req_colour;
    logic [3:0]  req_ready;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic [1:0]  grant_id;
    logic        busy;
    logic [7:0]  drop_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_drop = 0;
    int t_ref;

    logic [17:0] exp_q[$];
    int          xfer_idx_q[$];
    int          xfer_cyc_q[$];
    int          plot_cyc_q[$];

    logic [7:0] mon_x;
    logic [6:0] mon_y;
    logic [2:0] mon_c;

    draw_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .req_ready  (req_ready),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .grant_id   (grant_id),
        .busy       (busy),
        .drop_count (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: pop on every plot, push for every handshake seen on the inputs
    always @(negedge clk) begin
        if (vga_plot) begin
            plot_cyc_q.push_back(cyc);
            check_eq("plot_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check_eq("pixel", 32'({vga_x, vga_y, vga_colour}), 32'(exp_q.pop_front()));
            end
        end
        if (reset) begin
            exp_q.delete();
            exp_drop = 0;
        end else begin
            check_eq("ready_masked", 32'(req_ready & ~req_valid), 32'd0);
            check_eq("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i] && req_valid[i]) begin
                    mon_x = req_x[8*i +: 8];
                    mon_y = req_y[7*i +: 7];
                    mon_c = req_colour[3*i +: 3];
                    xfer_idx_q.push_back(i);
                    xfer_cyc_q.push_back(cyc);
                    if (mon_x < 8'd160 && mon_y < 7'd120) exp_q.push_back({mon_x, mon_y, mon_c});
                    else if (exp_drop < 255) exp_drop++;
                end
            end
        end
    end

    task automatic clear_logs();
        xfer_idx_q.delete();
        xfer_cyc_q.delete();
        plot_cyc_q.delete();
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_last  = '0;
        reset     = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        clear_logs();
    endtask

    // Present one pixel and hold it until the handshake; returns #1 after that edge
    task automatic send_pixel(input int idx, input logic [7:0] x, input logic [6:0] y,
                              input logic [2:0] c, input logic last);
        req_x[8*idx +: 8]      = x;
        req_y[7*idx +: 7]      = y;
        req_colour[3*idx +: 3] = c;
        req_last[idx]          = last;
        req_valid[idx]         = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (req_ready[idx]) break;
        end
        check_eq("ready_wait", 32'(req_ready[idx]), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic release_req(input int idx);
        req_valid[idx] = 1'b0;
        req_last[idx]  = 1'b0;
    endtask

    task automatic wait_xfers(input int n);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #1;
            if (xfer_idx_q.size() >= n) break;
        end
        check_eq("xfer_count", 32'(xfer_idx_q.size()), 32'(n));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1;
        req_valid = '0; req_last = '0; req_x = '0; req_y = '0; req_colour = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_grant", 32'(grant_id), 32'd0);
        check_eq("rst_plot", 32'(vga_plot), 32'd0);
        check_eq("rst_drop", 32'(drop_count), 32'd0);
        check_eq("rst_pix", 32'({vga_x, vga_y, vga_colour}), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        clear_logs();

        // Single three-pixel burst from requester 0
        t_ref = cyc;
        send_pixel(0, 8'd10, 7'd20, 3'd1, 1'b0);
        send_pixel(0, 8'd11, 7'd21, 3'd2, 1'b0);
        send_pixel(0, 8'd12, 7'd22, 3'd3, 1'b1);
        release_req(0);
        check_eq("b1_busy_after_last", 32'(busy), 32'd0);
        check_eq("b1_grant", 32'(grant_id), 32'd0);
        @(negedge clk);
        #1;
        check_eq("b1_plots", 32'(plot_cyc_q.size()), 32'd3);
        for (int k = 0; k < 3; k++) check_eq("b1_plot_cyc", 32'(plot_cyc_q[k]), 32'(t_ref + 2 + k));

        // All four requesting, one-pixel bursts: rotating grants with an idle gap
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_x[8*i +: 8] = 8'(40 + i);
            req_y[7*i +: 7] = 7'(50 + i);
            req_colour[3*i +: 3] = 3'(i + 4);
        end
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        wait_xfers(5);
        @(posedge clk);
        #1 req_valid = '0; req_last = '0;
        for (int k = 0; k < 5; k++) check_eq("rr_order", 32'(xfer_idx_q[k]), 32'(k % 4));
        for (int k = 1; k < 5; k++) begin
            check_eq("rr_gap", 32'(xfer_cyc_q[k] - xfer_cyc_q[k-1]), 32'd2);
        end

        // Off-screen pixel dropped, corner pixel plotted, then saturation
        do_reset();
        send_pixel(1, 8'd160, 7'd5, 3'd4, 1'b0);
        send_pixel(1, 8'd159, 7'd119, 3'd5, 1'b1);
        release_req(1);
        @(negedge clk);
        #1;
        check_eq("drop_one", 32'(drop_count), 32'd1);
        check_eq("corner_xy", 32'({vga_x, vga_y}), 32'({8'd159, 7'd119}));
        for (int p = 0; p < 257; p++) send_pixel(2, 8'd10, 7'd120, 3'd0, p == 256);
        release_req(2);
        @(negedge clk);
        #1;
        check_eq("drop_sat", 32'(drop_count), 32'd255);
        check_eq("drop_model", 32'(drop_count), 32'(exp_drop));

        // Watchdog: short gap tolerated, 16-cycle stall releases the port
        do_reset();
        req_x[15:8] = 8'd30; req_y[13:7] = 7'd40; req_colour[5:3] = 3'd6;
        req_last[1] = 1'b1;
        req_valid[1] = 1'b1;
        send_pixel(0, 8'd1, 7'd2, 3'd3, 1'b0);
        release_req(0);
        repeat (10) @(posedge clk);
        #1;
        send_pixel(0, 8'd2, 7'd3, 3'd4, 1'b0);
        release_req(0);
        t_ref = xfer_cyc_q[1];
        check_eq("wd_first_grant", 32'(xfer_idx_q[1]), 32'd0);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check_eq("wd_busy_16th", 32'(busy), 32'd1);
        @(negedge clk);
        check_eq("wd_busy_release", 32'(busy), 32'd0);
        wait_xfers(3);
        check_eq("wd_next_grant", 32'(xfer_idx_q[2]), 32'd1);
        check_eq("wd_next_cyc", 32'(xfer_cyc_q[2]), 32'(t_ref + 18));
        @(posedge clk);
        #1 release_req(1);

        // enable low blocks new grants but never aborts a burst
        do_reset();
        enable = 1'b0;
        req_x[23:16] = 8'd70; req_y[20:14] = 7'd80; req_colour[8:6] = 3'd2;
        req_valid[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("en0_busy", 32'(busy), 32'd0);
            check_eq("en0_ready", 32'(req_ready), 32'd0);
            check_eq("en0_plot", 32'(vga_plot), 32'd0);
        end
        @(posedge clk);
        #1 enable = 1'b1;
        send_pixel(2, 8'd70, 7'd80, 3'd2, 1'b0);
        enable = 1'b0;
        send_pixel(2, 8'd71, 7'd81, 3'd3, 1'b0);
        send_pixel(2, 8'd72, 7'd82, 3'd4, 1'b0);
        send_pixel(2, 8'd73, 7'd83, 3'd5, 1'b1);
        release_req(2);
        @(negedge clk);
        #1;
        check_eq("en_burst_plots", 32'(plot_cyc_q.size()), 32'd4);
        check_eq("en_burst_done", 32'(busy), 32'd0);
        req_valid[0] = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("en0_after_burst", 32'(busy), 32'd0);
        @(posedge clk);
        #1 release_req(0);
        enable = 1'b1;

        // Reset mid-burst
        do_reset();
        send_pixel(3, 8'd200, 7'd0, 3'd1, 1'b0);
        send_pixel(3, 8'd5, 7'd6, 3'd2, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_plot", 32'(vga_plot), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_drop", 32'(drop_count), 32'd0);
        reset = 1'b0;
        clear_logs();
        req_x[7:0] = 8'd7; req_y[6:0] = 7'd8; req_colour[2:0] = 3'd1;
        req_valid = 4'b1001;
        req_last  = 4'b1001;
        wait_xfers(1);
        @(posedge clk);
        #1 req_valid = '0; req_last = '0;
        check_eq("post_rst_grant", 32'(xfer_idx_q[0]), 32'd0);

        repeat (3) @(negedge clk);
        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
